alu_issue_stage: RTL
====================

Name: alu_issue_stage

Overview:
- Decode/issue stage sitting directly upstream of the ALU.
- Accepts raw RV32I ALU instructions plus register-file read data and decodes OP and OP-IMM instructions into ALU operands a, b and the 4-bit select.
- Applies writeback forwarding and x0 zeroing.
- Presents results through a registered valid/ready interface, backed by a 2-entry skid buffer, that feeds the ALU/EX stage.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept; driven directly from a flop
- in_instr  in  32  instruction word
- in_rs1_data  in  XLEN  register-file read of rs1, same cycle as in_instr
- in_rs2_data  in  XLEN  register-file read of rs2, same cycle as in_instr
- fwd_valid  in  1  writeback result valid this cycle
- fwd_rd  in  REG_ADDR_W  writeback destination
- fwd_data  in  XLEN  writeback value
- flush  in  1  discard all held and incoming entries
- out_valid  out  1  issued operands valid
- out_ready  in  1  ALU/EX stage consumes
- out_a  out  XLEN  ALU operand a
- out_b  out  XLEN  ALU operand b
- out_sel  out  4  ALU select, codes from alu_op.vh
- out_rd  out  REG_ADDR_W  destination register
- out_illegal  out  1  instruction not a supported ALU op

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_a/out_b/out_rd=0, out_sel=ADD, out_illegal=0, both buffer entries empty, in_ready=1 from the first clock after deassertion.
- Handshakes:
  - Input transfer when in_valid&&in_ready.
  - Output transfer when out_valid&&out_ready.
  - out_* stable while out_valid&&!out_ready.
- Latency: an accepted instruction appears on out_* the next cycle when the buffer is empty.
- Buffer states EMPTY, ONE, TWO (main + skid):
  - EMPTY: accept -> ONE.
  - ONE: accept without consume -> TWO; consume without accept -> EMPTY; accept and consume -> ONE.
  - TWO: in_ready=0. Consume -> ONE, with the skid entry moving to main.
  - Strict FIFO order.
- Decode, opcode 0110011 (OP), per funct3:
  - 000: ADD if funct7=0000000, SUB if funct7=0100000.
  - 100: XOR.
  - 110: OR.
  - 111: AND.
  - 001: SLL.
  - Any other funct3, or a funct7 not listed, -> illegal. b=rs2 value.
- Decode, opcode 0010011 (OP-IMM), per funct3:
  - 000: ADD, b=sign-extended imm[11:0].
  - 100/110/111: XOR/OR/AND, imm sign-extended.
  - 001: SLL, legal only if funct7=0000000; b={27'b0,shamt[4:0]}.
  - Others illegal.
- Illegal instructions (any other opcode, or unsupported funct fields): out_illegal=1, out_sel=ADD, out_a=out_b=0, out_rd=0. Still occupies a slot and still handshakes.
- Operand source, resolved at capture:
  - A source index of 0 yields 0.
  - Otherwise, if fwd_valid && fwd_rd!=0 && fwd_rd==source index, use fwd_data.
  - Otherwise use in_rsN_data.
- Flush has priority over everything. Next cycle: both entries empty, out_valid=0, in_ready=1. An instruction presented in the flush cycle is dropped, and the upstream handshake still counts it as transferred.
- Reset mid-stall discards all entries immediately.

Optional Feature:
- ALU_ISSUE_STATS_EN defined: adds outputs stat_issued[31:0] and stat_illegal[31:0].
  - stat_issued increments on every output transfer; stat_illegal increments on output transfers with out_illegal=1.
  - Both wrap modulo 2^32, are cleared only by reset, and are unaffected by flush.
- Undefined: no such ports or logic.

Decomposition:
- Package alu_issue_pkg holds:
  - opcode constants OPC_OP, OPC_OP_IMM;
  - funct3 constants F3_ADD_SUB, F3_SLL, F3_XOR, F3_OR, F3_AND;
  - funct7 constants F7_BASE, F7_SUB;
  - a decoded_op struct {a, b, sel, rd, illegal}.
- ALU select codes stay in alu_op.vh.
- One combinational sub-module, alu_issue_decode: instruction + rs data + forward -> decoded_op. The top level holds the skid buffer and handshake.

Test Plan:
- ADDI x5,x1,-3 (0xFFD08293), rs1_data=10, out_ready=1 -> next cycle out_valid=1, a=10, b=0xFFFFFFFD, sel=ADD, rd=5, illegal=0.
- SUB x3,x1,x2 (0x402081B3), rs1=2032, rs2=32 -> a=2032, b=32, sel=SUB, rd=3. Repeat with fwd_valid=1, fwd_rd=2, fwd_data=7 -> b=7.
- Operand x0: ADD with rs1=x0, rs1_data=0xDEADBEEF, fwd_rd=0, fwd_valid=1 -> a=0.
- Backpressure: out_ready=0, three back-to-back valid instructions -> two accepted, in_ready=0 from the cycle after the second. Raise out_ready -> both emerge in order, in_ready=1 one cycle after the first consume.
- Illegal: 0x00000073 -> out_illegal=1, a=b=0, sel=ADD. SLLI with funct7=0100000 -> illegal.
- Flush with both entries full plus in_valid=1 -> next cycle out_valid=0, in_ready=1, and the dropped instruction never appears.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared types and constants for the ALU issue stage.
// Opcode/funct constants, decoded_op bundle, buffer states.
package alu_issue_pkg;
`include "alu_op.vh"

    localparam int DATA_W = 32;
    localparam int RIDX_W = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    localparam logic [3:0] SEL_ADD = `ALU_ADD;
    localparam logic [3:0] SEL_SUB = `ALU_SUB;
    localparam logic [3:0] SEL_SLL = `ALU_SLL;
    localparam logic [3:0] SEL_XOR = `ALU_XOR;
    localparam logic [3:0] SEL_OR  = `ALU_OR;
    localparam logic [3:0] SEL_AND = `ALU_AND;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [3:0]        sel;
        logic [RIDX_W-1:0] rd;
        logic              illegal;
    } decoded_op;

    localparam decoded_op NOP_OP = '{
        a: '0, b: '0, sel: `ALU_ADD, rd: '0, illegal: 1'b0
    };

    typedef enum logic [1:0] {
        BUF_EMPTY,
        BUF_ONE,
        BUF_TWO
    } buf_state_t;
endpackage

// File: rtl/alu_issue_decode.sv
// Combinational OP/OP-IMM decoder with forwarding and x0 zeroing.
// Ports: instr, rs1/rs2 data, writeback forward -> decoded_op dec.
module alu_issue_decode
    import alu_issue_pkg::*;
(
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    input  logic              fwd_valid,
    input  logic [RIDX_W-1:0] fwd_rd,
    input  logic [DATA_W-1:0] fwd_data,
    output decoded_op         dec
);
    logic [6:0]        opc;
    logic [2:0]        f3;
    logic [6:0]        f7;
    logic [RIDX_W-1:0] rs1;
    logic [RIDX_W-1:0] rs2;
    logic [RIDX_W-1:0] rd;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] shamt;
    logic [DATA_W-1:0] b_imm;
    logic [3:0]        sel;
    logic              legal;
    logic              use_imm;

    assign opc   = instr[6:0];
    assign rd    = instr[11:7];
    assign f3    = instr[14:12];
    assign rs1   = instr[19:15];
    assign rs2   = instr[24:20];
    assign f7    = instr[31:25];
    assign imm   = {{20{instr[31]}}, instr[31:20]};
    assign shamt = {27'b0, instr[24:20]};

    // Index 0 already excludes fwd_rd==0 from matching.
    assign src1 = (rs1 == '0) ? '0 :
                  (fwd_valid && fwd_rd == rs1) ? fwd_data : rs1_data;
    assign src2 = (rs2 == '0) ? '0 :
                  (fwd_valid && fwd_rd == rs2) ? fwd_data : rs2_data;

    always_comb begin
        legal   = 1'b0;
        sel     = `ALU_ADD;
        use_imm = 1'b0;
        b_imm   = imm;
        unique case (1'b1)
            opc == OPC_OP: begin
                unique case (f3)
                    F3_ADD_SUB: begin
                        if (f7 == F7_BASE) begin
                            legal = 1'b1;
                            sel   = `ALU_ADD;
                        end else if (f7 == F7_SUB) begin
                            legal = 1'b1;
                            sel   = `ALU_SUB;
                        end
                    end
                    F3_XOR: begin legal = (f7 == F7_BASE); sel = `ALU_XOR; end
                    F3_OR:  begin legal = (f7 == F7_BASE); sel = `ALU_OR;  end
                    F3_AND: begin legal = (f7 == F7_BASE); sel = `ALU_AND; end
                    F3_SLL: begin legal = (f7 == F7_BASE); sel = `ALU_SLL; end
                    default: legal = 1'b0;
                endcase
            end
            opc == OPC_OP_IMM: begin
                use_imm = 1'b1;
                unique case (f3)
                    F3_ADD_SUB: begin legal = 1'b1; sel = `ALU_ADD; end
                    F3_XOR:     begin legal = 1'b1; sel = `ALU_XOR; end
                    F3_OR:      begin legal = 1'b1; sel = `ALU_OR;  end
                    F3_AND:     begin legal = 1'b1; sel = `ALU_AND; end
                    F3_SLL: begin
                        legal = (f7 == F7_BASE);
                        sel   = `ALU_SLL;
                        b_imm = shamt;
                    end
                    default: legal = 1'b0;
                endcase
            end
            default: legal = 1'b0;
        endcase

        dec = NOP_OP;
        if (legal) begin
            dec.a   = src1;
            dec.b   = use_imm ? b_imm : src2;
            dec.sel = sel;
            dec.rd  = rd;
        end else begin
            dec.illegal = 1'b1;
        end
    end
endmodule

// File: rtl/alu_op.vh
// ALU select encodings shared by the issue stage and the ALU.
// Four-bit codes driven on out_sel.
`ifndef ALU_OP_VH
`define ALU_OP_VH
`define ALU_ADD 4'b0000
`define ALU_SUB 4'b1000
`define ALU_SLL 4'b0001
`define ALU_XOR 4'b0100
`define ALU_OR  4'b0110
`define ALU_AND 4'b0111
`endif

// File: rtl/alu_issue_stage.sv
// Issue stage: decode + 2-entry skid buffer feeding the ALU/EX stage.
// Ports: in_* upstream handshake, fwd_* writeback, out_* to ALU; ALU_ISSUE_STATS_EN adds stat_*.
module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int XLEN       = DATA_W,
    parameter int REG_ADDR_W = RIDX_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           in_instr,
    input  logic [XLEN-1:0]       in_rs1_data,
    input  logic [XLEN-1:0]       in_rs2_data,
    input  logic                  fwd_valid,
    input  logic [REG_ADDR_W-1:0] fwd_rd,
    input  logic [XLEN-1:0]       fwd_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       out_a,
    output logic [XLEN-1:0]       out_b,
    output logic [3:0]            out_sel,
    output logic [REG_ADDR_W-1:0] out_rd,
`ifdef ALU_ISSUE_STATS_EN
    output logic [31:0]           stat_issued,
    output logic [31:0]           stat_illegal,
`endif
    output logic                  out_illegal
);
    buf_state_t state_q, state_d;
    decoded_op  main_q, main_d;
    decoded_op  skid_q, skid_d;
    decoded_op  dec;
    logic       in_ready_q;
    logic       acc;
    logic       cons;

    alu_issue_decode u_dec (
        .instr    (in_instr),
        .rs1_data (in_rs1_data),
        .rs2_data (in_rs2_data),
        .fwd_valid(fwd_valid),
        .fwd_rd   (fwd_rd),
        .fwd_data (fwd_data),
        .dec      (dec)
    );

    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q != BUF_EMPTY);
    assign out_a       = main_q.a;
    assign out_b       = main_q.b;
    assign out_sel     = main_q.sel;
    assign out_rd      = main_q.rd;
    assign out_illegal = main_q.illegal;

    assign acc  = in_valid && in_ready_q;
    assign cons = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = BUF_EMPTY;
        end else begin
            unique case (state_q)
                BUF_EMPTY: begin
                    if (acc) begin
                        main_d  = dec;
                        state_d = BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (acc && !cons) begin
                        skid_d  = dec;
                        state_d = BUF_TWO;
                    end else if (acc && cons) begin
                        main_d = dec;
                    end else if (cons) begin
                        state_d = BUF_EMPTY;
                    end
                end
                BUF_TWO: begin
                    if (cons) begin
                        main_d  = skid_q;
                        state_d = BUF_ONE;
                    end
                end
                default: state_d = BUF_EMPTY;
            endcase
        end
    end

    // in_ready is registered: it looks ahead at the next occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BUF_EMPTY;
            in_ready_q <= 1'b0;
            main_q     <= NOP_OP;
            skid_q     <= NOP_OP;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != BUF_TWO);
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end

`ifdef ALU_ISSUE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued  <= '0;
            stat_illegal <= '0;
        end else if (cons) begin
            stat_issued <= stat_issued + 32'd1;
            if (main_q.illegal)
                stat_illegal <= stat_illegal + 32'd1;
        end
    end
`endif
endmodule
